nibble_sched: RTL and testbench
===============================

// Module: nibble_sched
// PURPOSE
//  - Sequencer for the 32-bit to 4-bit symbol-select datapath in the Zigbee TX chain.
//  - Accepts 32-bit words from the byte/framing stage over a valid/ready handshake.
//  - Steps the select through the 8 nibbles, low nibble first (802.15.4 order).
//  - Presents each 4-bit symbol to the chip spreader over a valid/ready handshake.
//  - Holds one prefetched word, so the symbol stream has no bubble at word boundaries.
// PARAMETERS
//  WORD_W  32  input word width; must be a multiple of SYM_W
//  SYM_W   4   symbol width (one O-QPSK data symbol)
//  NSYM    8   symbols per word, derived = WORD_W/SYM_W; not overridable
// PORTS
//  inClk       in   1       single clock, rising edge
//  inRstn      in   1       asynchronous active-low reset
//  inData      in   WORD_W  word to serialize, sampled when inValid && outReady
//  inValid     in   1       upstream word valid
//  outReady    out  1       upstream may transfer (prefetch slot free)
//  inFlush     in   1       synchronous abort: drop current and prefetched words
//  outSym      out  SYM_W   current symbol = cur_word[idx*SYM_W +: SYM_W]
//  outValid    out  1       outSym valid
//  inSymReady  in   1       spreader accepts outSym this cycle
//  outBusy     out  1       cur or prefetch word held
// BEHAVIOUR
//  - Reset (inRstn=0, async): state=IDLE, idx=0, cur_v=0, nxt_v=0.
//  - Reset values: outValid=0, outReady=0, outBusy=0, outSym=0.
//  - outReady rises the first clock after reset release.
//  - Storage: cur_word, cur_v, nxt_word, nxt_v, idx[2:0]. outReady = !nxt_v && !inFlush.
//  - States: IDLE (cur_v=0) and RUN (cur_v=1). outValid = (state==RUN).
//  - IDLE: a word accepted -> cur_word, idx=0, RUN next cycle (1-cycle input-to-symbol latency).
//  - RUN, handshake outValid&&inSymReady with idx<7 -> idx+1.
//  - RUN, handshake at idx==7, nxt_v=1 -> cur<=nxt, nxt_v=0, idx=0, stay RUN (no bubble).
//  - RUN, handshake at idx==7, nxt_v=0, word arriving same cycle -> goes straight to cur, idx=0, stay RUN.
//  - RUN, handshake at idx==7, nothing pending -> IDLE, idx=0.
//  - RUN, word accepted, not moving to cur -> nxt slot.
//  - outReady=1 in RUN while nxt free, so at most 2 words are held.
//  - No handshake (inSymReady=0): outSym and idx hold stable; outValid stays 1 and is never withdrawn.
//  - Simultaneous final-symbol handshake and input accept: both happen; ordering preserved.
//  - inFlush=1: next edge cur_v=nxt_v=0, idx=0, IDLE.
//  - inFlush overrides every other event in that cycle; a word offered with inFlush is not accepted.
//  - outBusy = cur_v || nxt_v.
//  - outSym = 0 whenever outValid=0, so no stale data reaches the spreader.
// CONFIGURATION
//  - NIBSCHED_LAST_EN defined:
//    - adds inLast (in, 1) and outLast (out, 1).
//    - inLast is stored with each word, alongside cur_word and nxt_word.
//    - outLast=1 only while outValid && idx==7 && the current word's last flag is set; reset 0.
//    - After the last symbol of a last-flagged word is handshaken, state goes to IDLE even if nxt_v=1.
//    - That next word starts one cycle later (frame gap of one cycle).
//  - NIBSCHED_LAST_EN undefined: no inLast/outLast ports; continuous streaming as above.
// STRUCTURE
//  - Package nibble_sched_pkg:
//    - WORD_W, SYM_W, NSYM constants.
//    - typedef enum logic {IDLE, RUN} nsched_state_t.
//    - typedef logic [$clog2(NSYM)-1:0] sym_idx_t.
//  - Sub-module: nibble_mux, a combinational 8:1 SYM_W-bit select. It is the datapath this block drives.
//  - Remaining logic is in nibble_sched: FSM, idx counter, two word registers, handshake logic.
// TESTING
//  - T1 reset/basic:
//    - Stimulus: inRstn low mid-stream, then send 0x76543210 with inSymReady=1.
//    - Expected: all outputs 0 during reset; outSym 0,1,...,7 on 8 consecutive cycles, first one cycle after accept.
//  - T2 back-to-back:
//    - Stimulus: words 0x76543210 then 0xFEDCBA98 held valid.
//    - Expected: 16 symbols 0..F with no gap; outReady low while nxt_v=1.
//  - T3 backpressure:
//    - Stimulus: inSymReady toggled randomly with the 0x89ABCDEF stream.
//    - Expected: outSym stable while stalled; emitted order F,E,D,C,B,A,9,8.
//  - T4 flush:
//    - Stimulus: inFlush at idx=3 with nxt held.
//    - Expected: next cycle outValid=0, outBusy=0.
//    - Then: the next word serializes from idx 0.
//  - T5 boundary:
//    - Stimulus: final-symbol handshake and a new word offered in the same cycle, nxt empty.
//    - Expected: new word's symbol 0 on the next cycle.
//  - T6 (NIBSCHED_LAST_EN):
//    - Stimulus: inLast=1 on word A, word B prefetched.
//    - Expected: outLast=1 only on A's symbol 7; one IDLE cycle, then B symbol 0.

Source files
------------

// File: rtl/nibble_sched_pkg.sv
// Shared constants and types for the nibble scheduler (32-bit word to 4-bit symbol sequencer).
package nibble_sched_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned SYM_W  = 4;
    localparam int unsigned NSYM   = WORD_W / SYM_W;
    localparam int unsigned IDX_W  = $clog2(NSYM);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } nsched_state_t;

    typedef logic [$clog2(NSYM)-1:0] sym_idx_t;

    // One held word plus its end-of-frame flag
    typedef struct packed {
        logic              last;
        logic [WORD_W-1:0] data;
    } word_slot_t;

    localparam sym_idx_t LAST_IDX = sym_idx_t'(NSYM - 1);

endpackage

// File: rtl/nibble_mux.sv
// Combinational NSYM:1 symbol select over a WORD_W-bit word, symbol 0 in the low bits.
module nibble_mux
    import nibble_sched_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    input  sym_idx_t          sel,
    output logic [SYM_W-1:0]  sym_c
);

    always_comb begin
        sym_c = '0;
        for (int unsigned i = 0; i < NSYM; i++) begin
            if (sel == sym_idx_t'(i)) begin
                sym_c = word[i*SYM_W +: SYM_W];
            end
        end
    end

endmodule

// File: rtl/nibble_sched.sv
// Word-to-symbol sequencer with a one-word prefetch slot for bubble-free streaming.
// Optional end-of-frame marking (inLast/outLast) is enabled with NIBSCHED_LAST_EN.
module nibble_sched
    import nibble_sched_pkg::*;
(
    input  logic              inClk,
    input  logic              inRstn,
    input  logic [WORD_W-1:0] inData,
    input  logic              inValid,
    output logic              outReady,
    input  logic              inFlush,
    output logic [SYM_W-1:0]  outSym,
    output logic              outValid,
    input  logic              inSymReady,
`ifdef NIBSCHED_LAST_EN
    input  logic              inLast,
    output logic              outLast,
`endif
    output logic              outBusy
);

    nsched_state_t state_q, state_d;
    sym_idx_t      idx_q, idx_d;
    word_slot_t    cur_q, cur_d;
    word_slot_t    nxt_q, nxt_d;
    logic          nxt_v_q, nxt_v_d;
    logic          rdy_en_q;

    logic          in_last;
    word_slot_t    in_slot;
    logic          accept;
    logic          sym_hs;
    logic          last_sym;
    logic [SYM_W-1:0] mux_sym_c;

`ifdef NIBSCHED_LAST_EN
    assign in_last = inLast;
`else
    assign in_last = 1'b0;
`endif

    assign in_slot  = '{last: in_last, data: inData};
    assign outReady = rdy_en_q && !nxt_v_q && !inFlush;
    assign accept   = inValid && outReady;
    assign outValid = (state_q == RUN);
    assign sym_hs   = outValid && inSymReady;
    assign last_sym = (idx_q == LAST_IDX);
    assign outBusy  = outValid || nxt_v_q;
    assign outSym   = outValid ? mux_sym_c : '0;

`ifdef NIBSCHED_LAST_EN
    assign outLast  = outValid && last_sym && cur_q.last;
`endif

    nibble_mux u_mux (
        .word  (cur_q.data),
        .sel   (idx_q),
        .sym_c (mux_sym_c)
    );

    // Ready is held off until the first clock after reset release
    always_ff @(posedge inClk or negedge inRstn) begin
        if (!inRstn) begin
            rdy_en_q <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
        end
    end

    always_ff @(posedge inClk or negedge inRstn) begin
        if (!inRstn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cur_q   <= '0;
            nxt_q   <= '0;
            nxt_v_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cur_q   <= cur_d;
            nxt_q   <= nxt_d;
            nxt_v_q <= nxt_v_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cur_d   = cur_q;
        nxt_d   = nxt_q;
        nxt_v_d = nxt_v_q;

        if (inFlush) begin
            state_d = IDLE;
            idx_d   = '0;
            nxt_v_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    idx_d = '0;
                    // A prefetched word only waits here after a frame gap
                    if (nxt_v_q) begin
                        cur_d   = nxt_q;
                        nxt_v_d = 1'b0;
                        state_d = RUN;
                    end else if (accept) begin
                        cur_d   = in_slot;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (sym_hs && last_sym) begin
                        idx_d = '0;
                        if (cur_q.last) begin
                            state_d = IDLE;
                            if (accept) begin
                                nxt_d   = in_slot;
                                nxt_v_d = 1'b1;
                            end
                        end else if (nxt_v_q) begin
                            cur_d   = nxt_q;
                            nxt_v_d = 1'b0;
                        end else if (accept) begin
                            cur_d = in_slot;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        if (sym_hs) begin
                            idx_d = sym_idx_t'(idx_q + 1'b1);
                        end
                        if (accept) begin
                            nxt_d   = in_slot;
                            nxt_v_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_sched.sv
// Directed self-checking bench for nibble_sched; T6 runs only when NIBSCHED_LAST_EN is defined.
module tb_nibble_sched;
    import nibble_sched_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [WORD_W-1:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              out_ready;
    logic              in_flush = 1'b0;
    logic [SYM_W-1:0]  out_sym;
    logic              out_valid;
    logic              in_sym_ready = 1'b0;
    logic              out_busy;
`ifdef NIBSCHED_LAST_EN
    logic              in_last = 1'b0;
    logic              out_last;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [WORD_W-1:0] word_q[$];
    logic [SYM_W-1:0]  exp_q[$];

    always #5 clk = ~clk;

    nibble_sched dut (
        .inClk      (clk),
        .inRstn     (rst_n),
        .inData     (in_data),
        .inValid    (in_valid),
        .outReady   (out_ready),
        .inFlush    (in_flush),
        .outSym     (out_sym),
        .outValid   (out_valid),
        .inSymReady (in_sym_ready),
`ifdef NIBSCHED_LAST_EN
        .inLast     (in_last),
        .outLast    (out_last),
`endif
        .outBusy    (out_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_sym"},   32'(out_sym),   32'd0);
        check({tag, "_busy"},  32'(out_busy),  32'd0);
    endtask

    task automatic push_word(input logic [WORD_W-1:0] w);
        word_q.push_back(w);
        for (int i = 0; i < int'(NSYM); i++) begin
            exp_q.push_back(w[i*SYM_W +: SYM_W]);
        end
    endtask

    // Streams word_q against exp_q from an empty DUT; a word-count model predicts ready/busy/valid
    task automatic run_stream(input int max_cyc, input bit rand_rdy, output int gaps);
        int got = 0;
        int cyc = 0;
        int acc_n = 0;
        int held;
        int n_exp;
        bit started = 1'b0;
        bit stalled = 1'b0;
        bit accepted;
        logic [SYM_W-1:0] held_sym = '0;
        n_exp = exp_q.size();
        gaps = 0;
        while (got < n_exp && cyc < max_cyc) begin
            in_valid     = (word_q.size() != 0);
            in_data      = in_valid ? word_q[0] : '0;
            in_sym_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            held = acc_n - got / int'(NSYM);
            check("mdl_ready", 32'(out_ready), 32'(held < 2));
            check("mdl_busy",  32'(out_busy),  32'(held > 0));
            check("mdl_valid", 32'(out_valid), 32'(held > 0));
            if (stalled) begin
                check("stall_hold", 32'(out_sym), 32'(held_sym));
            end
            accepted = in_valid && (held < 2);
            if (out_valid) started = 1'b1;
            else if (started) gaps++;
            stalled = 1'b0;
            if (out_valid && in_sym_ready) begin
                check("sym", 32'(out_sym), 32'(exp_q[got]));
                got++;
            end else if (out_valid) begin
                stalled  = 1'b1;
                held_sym = out_sym;
            end
            @(posedge clk);
            if (accepted) begin
                void'(word_q.pop_front());
                acc_n++;
            end
            @(negedge clk);
            cyc++;
        end
        if (got < n_exp) check("stream_timeout", 32'(got), 32'(n_exp));
        in_valid     = 1'b0;
        in_sym_ready = 1'b0;
        word_q.delete();
        exp_q.delete();
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        int gaps;
        logic [WORD_W-1:0] w;

        // T1: reset state and single word
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ready", 32'(out_ready), 32'd0);
        check("rst_busy",  32'(out_busy),  32'd0);
        check("rst_sym",   32'(out_sym),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_ready0", 32'(out_ready), 32'd0);
        @(negedge clk);
        #1;
        check("rel_ready1", 32'(out_ready), 32'd1);

        push_word(32'h76543210);
        run_stream(40, 1'b0, gaps);
        check_idle("t1_end");

        // Reset asserted mid-stream
        @(negedge clk);
        in_valid = 1'b1;
        in_data = 32'h76543210;
        in_sym_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_ready", 32'(out_ready), 32'd0);
        check("mid_rst_busy",  32'(out_busy),  32'd0);
        check("mid_rst_sym",   32'(out_sym),   32'd0);
        @(negedge clk);
        in_sym_ready = 1'b0;
        rst_n = 1'b1;
        #1;
        check("mid_rel_ready0", 32'(out_ready), 32'd0);
        @(negedge clk);
        #1;
        check("mid_rel_ready1", 32'(out_ready), 32'd1);

        // T2: back-to-back words, no bubble
        push_word(32'h76543210);
        push_word(32'hFEDCBA98);
        run_stream(60, 1'b0, gaps);
        check("t2_gaps", 32'(gaps), 32'd0);
        check_idle("t2_end");

        // T3: random backpressure
        push_word(32'h89ABCDEF);
        run_stream(400, 1'b1, gaps);
        check_idle("t3_end");

        // T4: flush at idx 3 with prefetch held; the word offered with flush is dropped
        @(negedge clk);
        in_valid = 1'b1;
        in_data = 32'h76543210;
        in_sym_ready = 1'b0;
        #1;
        check("t4_ready_a", 32'(out_ready), 32'd1);
        @(negedge clk);
        in_data = 32'hFEDCBA98;
        #1;
        check("t4_sym0", 32'(out_sym), 32'h0);
        check("t4_ready_b", 32'(out_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_sym_ready = 1'b1;
        #1;
        check("t4_nxt_full", 32'(out_ready), 32'd0);
        check("t4_busy", 32'(out_busy), 32'd1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("t4_sym3", 32'(out_sym), 32'h3);
        in_flush = 1'b1;
        in_valid = 1'b1;
        in_data = 32'h11111111;
        #1;
        check("t4_flush_ready", 32'(out_ready), 32'd0);
        @(negedge clk);
        in_flush = 1'b0;
        in_valid = 1'b0;
        in_sym_ready = 1'b0;
        #1;
        check_idle("t4_flushed");
        check("t4_ready_after", 32'(out_ready), 32'd1);
        push_word(32'hA5C3E1F0);
        run_stream(40, 1'b0, gaps);
        check_idle("t4_end");

        // T5: final-symbol handshake and new word in the same cycle, nxt empty
        @(negedge clk);
        in_valid = 1'b1;
        in_data = 32'h76543210;
        in_sym_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            #1;
            check("t5_a_sym", 32'(out_sym), 32'(k));
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data = 32'h3C2B1A09;
        #1;
        check("t5_sym7", 32'(out_sym), 32'h7);
        check("t5_ready", 32'(out_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        w = 32'h3C2B1A09;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("t5_b_valid", 32'(out_valid), 32'd1);
            check("t5_b_sym", 32'(out_sym), 32'(w[k*SYM_W +: SYM_W]));
            @(negedge clk);
        end
        in_sym_ready = 1'b0;
        #1;
        check_idle("t5_end");

`ifdef NIBSCHED_LAST_EN
        // T6: last-flagged word A, B prefetched; one idle cycle between frames
        @(negedge clk);
        in_valid = 1'b1;
        in_data = 32'h76543210;
        in_last = 1'b1;
        in_sym_ready = 1'b1;
        @(negedge clk);
        in_data = 32'hFEDCBA98;
        in_last = 1'b0;
        #1;
        check("t6_sym0", 32'(out_sym), 32'h0);
        check("t6_last0", 32'(out_last), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 1; k < 8; k++) begin
            #1;
            check("t6_a_sym", 32'(out_sym), 32'(k));
            check("t6_a_last", 32'(out_last), 32'(k == 7));
            @(negedge clk);
        end
        #1;
        check("t6_gap_valid", 32'(out_valid), 32'd0);
        check("t6_gap_busy", 32'(out_busy), 32'd1);
        check("t6_gap_last", 32'(out_last), 32'd0);
        @(negedge clk);
        #1;
        check("t6_b_valid", 32'(out_valid), 32'd1);
        check("t6_b_sym0", 32'(out_sym), 32'h8);
        check("t6_b_last", 32'(out_last), 32'd0);
        in_sym_ready = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
